// File: rtl/avmm_pio_gen2.sv
// ---------------------------------------------------------------------------
// avmm_pio_gen2
//
// Parametrised Avalon-MM general-purpose I/O block. It has two halves:
//   * An output register with atomic set and clear aliases, driving pio_out.
//   * An input path. Each bit passes through a 2-FF synchroniser and then a
//     debouncer clocked by one shared prescaler tick. Per-bit rising and
//     falling edges are captured, and a maskable level interrupt is raised.
//
// Register map (word addresses):
//   0 IN        RO   debounced input level
//   1 OUT       RW   output register
//   2 IRQ_MASK  RW   interrupt enables for EDGE_CAP bits
//   3 EDGE_CAP  R/W1C captured edges
//   4 OUTSET    WO   OUT |= wdata   (reads 0)
//   5 OUTCLR    WO   OUT &= ~wdata  (reads 0)
//   6 RISE_EN   RW   capture rising edges
//   7 FALL_EN   RW   capture falling edges
//
// Ports:
//   clk_clk            sole clock
//   reset_reset_n      asynchronous active-low reset
//   avs_address        word address (3 bits)
//   avs_read           read strobe; data returns one cycle later
//   avs_write          write strobe; takes effect at this clock edge
//   avs_writedata      32-bit write data; bits above the field width are ignored
//   avs_readdata       registered read data, zero-extended
//   avs_readdatavalid  pulses exactly one cycle after avs_read
//   pio_in             asynchronous external inputs (IN_WIDTH bits)
//   pio_out            output register (OUT_WIDTH bits)
//   irq                level interrupt, |(EDGE_CAP & IRQ_MASK)
// ---------------------------------------------------------------------------
module avmm_pio_gen2 #(
    parameter int unsigned IN_WIDTH        = 4,
    parameter int unsigned OUT_WIDTH       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] OUT_RESET       = 32'h0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out,
    output logic                 irq
);

    localparam int unsigned         CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [OUT_WIDTH-1:0] OUT_INIT = OUT_RESET[OUT_WIDTH-1:0];

    localparam logic [2:0] ADDR_IN       = 3'd0;
    localparam logic [2:0] ADDR_OUT      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

    // Input path state
    logic [IN_WIDTH-1:0]  sync_meta;
    logic [IN_WIDTH-1:0]  sync_q;
    logic [IN_WIDTH-1:0]  samp;
    logic [IN_WIDTH-1:0]  db;
    logic [IN_WIDTH-1:0]  db_q;
    logic                 primed;
    logic                 db_q_valid;
    logic [CNT_W-1:0]     presc_cnt;
    logic                 tick;

    // Software-visible registers
    logic [OUT_WIDTH-1:0] out_reg;
    logic [IN_WIDTH-1:0]  irq_mask;
    logic [IN_WIDTH-1:0]  edge_cap;
    logic [IN_WIDTH-1:0]  rise_en;
    logic [IN_WIDTH-1:0]  fall_en;

    // Decoded bus strobes and derived vectors
    logic                 wr_out;
    logic                 wr_mask;
    logic                 wr_cap;
    logic                 wr_set;
    logic                 wr_clr;
    logic                 wr_rise;
    logic                 wr_fall;
    logic [IN_WIDTH-1:0]  wdata_in;
    logic [OUT_WIDTH-1:0] wdata_out;
    logic [IN_WIDTH-1:0]  w1c;
    logic [IN_WIDTH-1:0]  agree;
    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  fall;
    logic [31:0]          rd_mux;

    // Upper write-data bits are deliberately ignored for narrow fields.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    assign wdata_in  = avs_writedata[IN_WIDTH-1:0];
    assign wdata_out = avs_writedata[OUT_WIDTH-1:0];

    always_comb begin
        wr_out  = 1'b0;
        wr_mask = 1'b0;
        wr_cap  = 1'b0;
        wr_set  = 1'b0;
        wr_clr  = 1'b0;
        wr_rise = 1'b0;
        wr_fall = 1'b0;
        if (avs_write) begin
            case (avs_address)
                ADDR_OUT:      wr_out  = 1'b1;
                ADDR_IRQ_MASK: wr_mask = 1'b1;
                ADDR_EDGE_CAP: wr_cap  = 1'b1;
                ADDR_OUTSET:   wr_set  = 1'b1;
                ADDR_OUTCLR:   wr_clr  = 1'b1;
                ADDR_RISE_EN:  wr_rise = 1'b1;
                ADDR_FALL_EN:  wr_fall = 1'b1;
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= pio_in;
            sync_q    <= sync_meta;
        end
    end

    // One prescaler is shared by all bits; tick marks the last count.
    assign tick = (presc_cnt == CNT_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // A level is accepted only when it is the same at two consecutive ticks.
    // The first tick after reset loads db directly so IN is meaningful early.
    assign agree = ~(sync_q ^ samp);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            samp   <= '0;
            db     <= '0;
            primed <= 1'b0;
        end else if (tick) begin
            samp <= sync_q;
            if (!primed) begin
                db     <= sync_q;
                primed <= 1'b1;
            end else begin
                db <= (db & ~agree) | (sync_q & agree);
            end
        end
    end

    // db_q only becomes a trustworthy "previous level" one cycle after the
    // priming tick; before that a nonzero priming value would look like a rise.
    assign rise = db_q_valid ? (db & ~db_q & rise_en) : '0;
    assign fall = db_q_valid ? (~db & db_q & fall_en) : '0;
    assign w1c  = wr_cap ? wdata_in : '0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db_q       <= '0;
            db_q_valid <= 1'b0;
            edge_cap   <= '0;
        end else begin
            db_q       <= db;
            db_q_valid <= primed;
            // New edges win over a same-cycle clear.
            edge_cap   <= (edge_cap & ~w1c) | rise | fall;
        end
    end

    // Plain RW registers and the atomic set/clear aliases of OUT.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_reg  <= OUT_INIT;
            irq_mask <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else begin
            if (wr_out) begin
                out_reg <= wdata_out;
            end else if (wr_set) begin
                out_reg <= out_reg | wdata_out;
            end else if (wr_clr) begin
                out_reg <= out_reg & ~wdata_out;
            end
            if (wr_mask) begin
                irq_mask <= wdata_in;
            end
            if (wr_rise) begin
                rise_en <= wdata_in;
            end
            if (wr_fall) begin
                fall_en <= wdata_in;
            end
        end
    end

    // Read mux sees pre-write register values, so a simultaneous read and
    // write to the same address returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_IN:       rd_mux[IN_WIDTH-1:0]  = db;
            ADDR_OUT:      rd_mux[OUT_WIDTH-1:0] = out_reg;
            ADDR_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask;
            ADDR_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap;
            ADDR_RISE_EN:  rd_mux[IN_WIDTH-1:0]  = rise_en;
            ADDR_FALL_EN:  rd_mux[IN_WIDTH-1:0]  = fall_en;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    assign pio_out = out_reg;
    assign irq     = |(edge_cap & irq_mask);

endmodule

// File: doc/avmm_pio_gen2.md
# avmm_pio_gen2

Parametrised Avalon-MM general-purpose I/O block, the next generation of the fixed 4-bit button, DIP-switch and LED PIOs in the SoC fabric. One instance drives a configurable-width output port with atomic set/clear. It also samples a configurable-width input port through a 2-FF synchroniser and a shared-prescaler debouncer, with per-bit rising/falling edge capture and a maskable level interrupt toward the HPS. It sits on the HPS lightweight bridge.

## Interface

- IN_WIDTH, 4: input bits, 1..32
- OUT_WIDTH, 4: output bits, 1..32
- DEBOUNCE_CYCLES, 50000: prescaler period in clk cycles, ≥2
- OUT_RESET, 0: reset value of output register (OUT_WIDTH bits)

Ports:
- clk_clk  in  1  sole clock
- reset_reset_n  in  1  asynchronous, active-low reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  registered read data
- avs_readdatavalid  out  1  pulses 1 cycle after avs_read
- pio_in  in  IN_WIDTH  asynchronous external inputs
- pio_out  out  OUT_WIDTH  output register
- irq  out  1  level interrupt

## Operation

- Register map:
  - 0 IN (RO): debounced input.
  - 1 OUT (RW).
  - 2 IRQ_MASK (RW).
  - 3 EDGE_CAP (R, write-1-to-clear).
  - 4 OUTSET (WO): OUT |= wdata.
  - 5 OUTCLR (WO): OUT &= ~wdata.
  - 6 RISE_EN (RW).
  - 7 FALL_EN (RW).
- Field widths: IN, IRQ_MASK, EDGE_CAP, RISE_EN and FALL_EN are IN_WIDTH bits; OUT is OUT_WIDTH bits. Unused upper bits read 0 and are ignored on write.
- Writes to RO addresses are ignored. WO addresses read 0.
- Synchroniser: two flops per input bit, producing sync.
- Prescaler: counts 0..DEBOUNCE_CYCLES-1 and wraps. A tick is asserted in the cycle the count equals DEBOUNCE_CYCLES-1.
- Debouncer state: samp and db per bit, plus a single primed flag.
  - First tick after reset (primed=0): samp<=sync, db<=sync, primed<=1. No edge capture.
  - Later ticks: samp<=sync. For each bit where sync==samp, db<=sync.
  - A level must agree at two consecutive ticks to be accepted. Pulses shorter than one tick period are rejected.
- Edge capture:
  - db_q is db delayed by one cycle.
  - rise = db & ~db_q & RISE_EN; fall = ~db & db_q & FALL_EN.
  - Edge capture is evaluated only once primed=1 and db_q is valid.
  - EDGE_CAP <= (EDGE_CAP & ~w1c) | rise | fall. Set wins over clear in the same cycle.
- irq = |(EDGE_CAP & IRQ_MASK). It is combinational from registers, so a change in mask or capture appears on irq the same cycle the register updates.
- Simultaneous read and write to the same address: the read returns the pre-write value.

## Timing

- Reset values:
  - pio_out = OUT_RESET.
  - All other registers = 0, primed = 0, prescaler = 0.
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0.
- Reset is applied asynchronously and released synchronously into the flops. Asserting reset mid-operation clears all state, including EDGE_CAP and primed.
- Read latency is fixed at 1. avs_readdata is registered and is valid with avs_readdatavalid exactly one cycle after avs_read. There is no waitrequest, and back-to-back reads are accepted every cycle.
- Write takes effect at the clock edge where avs_write=1. pio_out reflects it from the next cycle.
- Input to IN latency:
  - 2 synchroniser cycles, plus waiting for the first tick that samples the new level, plus one full tick period.
  - Worst case is 2 + 2·DEBOUNCE_CYCLES cycles.
- EDGE_CAP sets one cycle after db changes. irq asserts in the same cycle as EDGE_CAP.
- A W1C to EDGE_CAP drops irq on the next cycle unless an edge is captured in that same cycle.

## Test plan

Parameters for all scenarios: IN_WIDTH=4, OUT_WIDTH=4, DEBOUNCE_CYCLES=4, OUT_RESET=0.

1. Reset and reads.
   - Stimulus: release reset; read addresses 0..7.
   - Required: pio_out=0x0, irq=0. avs_readdatavalid pulses exactly one cycle after each read. All reads return 0.
2. Set/clear.
   - Stimulus: write OUT←0x5, then OUTSET←0xA, then OUTCLR←0x3, then read addr 1.
   - Required: pio_out goes 0x5, then 0xF, then 0xC. Readback is 0xC. A read of addr 4 returns 0.
3. Debounce.
   - Stimulus: with pio_in=0 primed, pulse pio_in[0]=1 for 3 cycles; later hold it high for 12 cycles.
   - Required: IN stays 0x0 through the 3-cycle glitch. IN reads 0x1 within 10 cycles of the rising edge on the 12-cycle hold.
4. Edge and irq.
   - Stimulus: RISE_EN=0x1, FALL_EN=0, IRQ_MASK=0x1. Drive pio_in[0] 0→1 stable, then write EDGE_CAP←0x1, then drive pio_in[0] 1→0 stable.
   - Required: EDGE_CAP=0x1 and irq=1 after the rise. irq=0 the cycle after the W1C. The fall captures nothing.
5. Collision.
   - Stimulus: issue a W1C of EDGE_CAP bit 1 in the same cycle as a new rise on bit 1, with RISE_EN=0x2.
   - Required: EDGE_CAP bit 1 remains 1 and irq stays asserted if the bit is masked in.
6. Reset mid-operation.
   - Stimulus: with EDGE_CAP=0x3 and pio_out=0xC, assert reset for 1 cycle while pio_in=0xF, then release.
   - Required: everything clears immediately and pio_out=0x0. After the first tick, IN=0xF with EDGE_CAP=0, because the priming tick captures no edges.
